uart_rx_x8: RTL and testbench
=============================

# uart_rx_x8

UART receiver that recovers 8N1 frames from the serial line using the 8x oversampling tick produced by the baud rate generator. It sits between the `rx` pad and the host-side byte interface. It runs on the system clock `fclk` with the 8x tick used only as a clock enable. Received bytes are presented through a valid/ack handshake with framing and overrun status.

## Interface
- `DATA_BITS`, 8: payload bits per frame, LSB first.
- `fclk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bx8_tick`  in  1  one-`fclk`-cycle enable pulse at 8x baud.
- `rx`  in  1  asynchronous serial input; idle high.
- `rx_ack`  in  1  host consumed `rx_data`; clears `rx_valid`.
- `rx_data`  out  DATA_BITS  last received payload.
- `rx_valid`  out  1  level; new payload available.
- `frame_err`  out  1  stop bit sampled low on the last frame.
- `overrun`  out  1  sticky; a frame completed while `rx_valid` was high.

## Operation
- `rx` passes through a 2-flop synchronizer, reset to 1, before any use.
- Sampling uses a 3-bit tick counter `os_cnt` that advances only on `bx8_tick`. The sample point is `os_cnt == 3`.
- FSM states and transitions:
  - IDLE: on a synchronized falling edge, clear `os_cnt` and go to START.
  - START: at the sample point, if `rx` is 1 this is a false start, so return to IDLE. Otherwise go to DATA at the `os_cnt` wrap.
  - DATA: sample once per bit at the sample point and shift LSB-first into `shreg`. After DATA_BITS samples, go to STOP at the wrap.
  - STOP: at the sample point, commit and return to IDLE immediately, without waiting for the wrap. This allows back-to-back frames.
- Commit (same `fclk` edge as the stop sample):
  - `rx_data <= shreg`, `rx_valid <= 1`, `frame_err <=` the inverted stop sample.
  - If `rx_valid` was already 1 and `rx_ack` is not asserted in the same cycle, set `overrun`. The data is overwritten.
- `rx_ack` clears `rx_valid` and `overrun` on the next edge.
- If `rx_ack` and a commit occur in the same cycle, the commit wins: `rx_valid` stays 1 and `overrun` is not set.
- `frame_err` holds until the next commit.
- A bit counter of width `$clog2(DATA_BITS+1)` counts received bits. `os_cnt` wraps modulo 8 with no saturation.

## Timing
- Reset values:
  - `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0.
  - FSM = IDLE, `os_cnt` = 0, synchronizer = 1.
- Reset mid-frame aborts the frame with no commit. The FSM is in IDLE on the cycle after `rst` is released.
- Input latency: 2 `fclk` cycles through the synchronizer.
- Falling-edge detection occurs 1 cycle after the synchronizer output changes.
- `rx_valid` rises on the `fclk` edge of the `bx8_tick` that is the stop-bit sample. It is visible the following cycle.
- Nominal frame-to-`rx_valid` latency: 9.5 bit times after the start edge, plus 3 `fclk` cycles.
- Bit-time tolerance: ±4/8 of a bit per frame, cumulatively.
- `bx8_tick` must be low for at least 1 cycle between pulses. Behaviour with a tick held high for multiple cycles is undefined.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds a PARITY state between DATA and STOP that samples one even-parity bit.
  - Adds output `parity_err` (1 bit, reset 0), updated at commit and set when the XOR of the data bits and the parity bit is 1.
  - Frame length becomes 11 bits.
- Undefined: no PARITY state and no `parity_err` port. The frame is 10 bits (8N1).

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `rx_state_t` (IDLE, START, DATA, PARITY, STOP).
  - `OVERSAMPLE = 8` and `MID_SAMPLE = 3`.
  - Reused later by the transmitter.
- One sub-module, `uart_rx_sync`: 2-flop synchronizer plus falling-edge detect. Outputs `rx_s` and `rx_fall`.

## Test plan
- Each item below gives stimulus -> required response.
- Frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB-first), valid stop -> `rx_data` = 0xA5, `rx_valid` = 1, `frame_err` = 0; `rx_ack` -> `rx_valid` = 0 next cycle.
- `rx` low for 2 ticks then high (glitch) -> FSM returns to IDLE and `rx_valid` stays 0. A following 0x3C frame is received correctly.
- Frame 0x81 with stop bit 0 -> `rx_data` = 0x81, `frame_err` = 1. The next good frame 0x00 clears `frame_err`.
- Back-to-back 0x11 then 0x22 with no `rx_ack` -> `rx_data` = 0x22, `overrun` = 1. `rx_ack` clears both flags.
- `rst` asserted during bit 4 of 0xFF -> all outputs 0. A subsequent 0x5A frame is received cleanly.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 1 -> `parity_err` = 0. Same frame with parity bit 0 -> `parity_err` = 1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver/transmitter state enum and oversampling constants
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  localparam int OVERSAMPLE = 8;
  localparam int MID_SAMPLE = 3;
endpackage

// File: rtl/uart_rx_x8_if.sv
// uart_rx_x8_if: host-side byte handshake; parity_err exists only with UART_RX_PARITY_EN
interface uart_rx_x8_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] rx_data;
  logic rx_valid, frame_err, overrun, rx_ack;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
  modport master (output rx_data, rx_valid, frame_err, overrun, parity_err, input rx_ack);
  modport slave (input rx_data, rx_valid, frame_err, overrun, parity_err, output rx_ack);
`else
  modport master (output rx_data, rx_valid, frame_err, overrun, input rx_ack);
  modport slave (input rx_data, rx_valid, frame_err, overrun, output rx_ack);
`endif
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for rx plus falling-edge detect on the synchronized line
module uart_rx_sync (
  input  logic fclk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);
  logic [2:0] sync_q;
  always_ff @(posedge fclk) sync_q <= rst ? '1 : {sync_q[1:0], rx};
  assign rx_s = sync_q[1];
  assign rx_fall = sync_q[2] & ~sync_q[1];
endmodule

// File: rtl/uart_rx_x8.sv
// uart_rx_x8: 8x-oversampled UART receiver with valid/ack handshake.
// Define UART_RX_PARITY_EN to add an even-parity bit and parity_err.
module uart_rx_x8 import uart_pkg::*; #(
  parameter int DATA_BITS = 8
) (
  input logic fclk,
  input logic rst,
  input logic bx8_tick,
  input logic rx,
  uart_rx_x8_if.master bus
);
  localparam int BW = $clog2(DATA_BITS + 1);
  rx_state_t state_q, state_d;
  logic [2:0] os_q, os_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic rx_s, rx_fall, samp, wrap, commit;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;
`endif
  uart_rx_sync u_sync (.fclk(fclk), .rst(rst), .rx(rx), .rx_s(rx_s), .rx_fall(rx_fall));
  assign samp = bx8_tick && os_q == 3'(MID_SAMPLE);
  assign wrap = bx8_tick && os_q == 3'(OVERSAMPLE - 1);
  always_comb begin
    state_d = state_q;
    os_d = bx8_tick ? os_q + 3'd1 : os_q;
    bit_d = bit_q;
    sh_d = sh_q;
    commit = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d = par_q;
`endif
    case (state_q)
      IDLE: if (rx_fall) begin
        state_d = START;
        os_d = '0;
      end
      START: if (samp && rx_s) state_d = IDLE;
        else if (wrap) begin
          state_d = DATA;
          bit_d = '0;
        end
      DATA: begin
        if (samp) begin
          sh_d = {rx_s, sh_q[DATA_BITS-1:1]};
          bit_d = bit_q + BW'(1);
        end
`ifdef UART_RX_PARITY_EN
        if (wrap && bit_q == BW'(DATA_BITS)) state_d = PARITY;
      end
      PARITY: begin
        if (samp) par_d = rx_s;
        if (wrap) state_d = STOP;
`else
        if (wrap && bit_q == BW'(DATA_BITS)) state_d = STOP;
`endif
      end
      // commit on the stop sample and skip the wrap so back-to-back frames are caught
      STOP: if (samp) begin
        commit = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign data_d = commit ? sh_q : data_q;
  assign valid_d = commit | (valid_q & ~bus.rx_ack);
  assign ferr_d = commit ? ~rx_s : ferr_q;
  assign ovr_d = (commit & valid_q & ~bus.rx_ack) | (ovr_q & ~bus.rx_ack);
`ifdef UART_RX_PARITY_EN
  assign perr_d = commit ? ^{sh_q, par_q} : perr_q;
  assign bus.parity_err = perr_q;
`endif
  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q <= IDLE;
      os_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      os_q <= os_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q <= par_d;
      perr_q <= perr_d;
`endif
    end
  end
  assign bus.rx_data = data_q;
  assign bus.rx_valid = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_uart_rx_x8.sv
// tb_uart_rx_x8: directed and random frames against a tick-counting reference model
module tb_uart_rx_x8;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic fclk = 0, rst = 1, bx8_tick = 0, rx = 1, ack_req = 0, rand_ack = 0, rnd_ack = 0;
  int cmp_n = 0, err_n = 0;
  uart_rx_x8_if #(.DATA_BITS(8)) bus ();
  uart_rx_x8 #(.DATA_BITS(8)) dut (.fclk(fclk), .rst(rst), .bx8_tick(bx8_tick), .rx(rx), .bus(bus));
  assign bus.rx_ack = rand_ack ? rnd_ack : ack_req;
  always #5 fclk = ~fclk;
  initial begin : tick_gen
    int c;
    c = 0;
    forever begin
      @(negedge fclk);
      bx8_tick = (c % 4 == 0);
      rnd_ack = ($urandom_range(0, 7) == 0);
      c++;
    end
  end
  task automatic chk(input string nm, input int a, input int e);
    cmp_n++;
    if (a !== e) begin
      err_n++;
      if (err_n <= 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  // reference: line delayed by three flops, bit k of a frame sampled on tick 8k+4 after start detect
  logic [2:0] h = '1;
  bit busy = 0;
  int n = 0;
  logic [7:0] sh = 0, e_data = 0;
  logic e_valid = 0, e_ferr = 0, e_ovr = 0, e_perr = 0, par = 0;
  always @(posedge fclk) begin : model
    logic commit, s;
    int idx;
    commit = 0;
    s = h[1];
    if (rst) begin
      h = '1; busy = 0; e_data = 0; e_valid = 0; e_ferr = 0; e_ovr = 0; e_perr = 0;
    end else begin
      if (!busy) begin
        if (h[2] && !h[1]) begin busy = 1; n = 0; end
      end else if (bx8_tick) begin
        n++;
        if (n % 8 == 4) begin
          idx = n / 8;
          if (idx == 0 && s) busy = 0;
          else if (idx >= 1 && idx <= 8) sh[idx-1] = s;
          else if (idx == NB - 1) begin commit = 1; busy = 0; end
          else if (idx == 9) par = s;
        end
      end
      e_ovr = (commit && e_valid && !bus.rx_ack) ? 1'b1 : bus.rx_ack ? 1'b0 : e_ovr;
      e_valid = commit || (e_valid && !bus.rx_ack);
      if (commit) begin
        e_data = sh;
        e_ferr = !s;
        e_perr = ^{sh, par};
      end
      h = {h[1:0], rx};
    end
    #1;
    chk("rx_data", bus.rx_data, e_data);
    chk("rx_valid", bus.rx_valid, e_valid);
    chk("frame_err", bus.frame_err, e_ferr);
    chk("overrun", bus.overrun, e_ovr);
`ifdef UART_RX_PARITY_EN
    chk("parity_err", bus.parity_err, e_perr);
`endif
  end
  task automatic wait_cyc(input int k);
    repeat (k) @(negedge fclk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stp, input logic pb, input int bt);
    rx = 0; wait_cyc(bt);
    for (int i = 0; i < 8; i++) begin rx = d[i]; wait_cyc(bt); end
`ifdef UART_RX_PARITY_EN
    rx = pb; wait_cyc(bt);
`endif
    rx = stp; wait_cyc(bt);
    rx = 1;
  endtask
  task automatic do_ack();
    ack_req = 1; wait_cyc(1); ack_req = 0;
  endtask
  initial begin : watchdog
    #700000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin : main
    wait_cyc(3); rst = 0; wait_cyc(1);
    chk("rst_data", bus.rx_data, 0);
    chk("rst_valid", bus.rx_valid, 0);
    chk("rst_ferr", bus.frame_err, 0);
    chk("rst_ovr", bus.overrun, 0);
    send_frame(8'hA5, 1, 0, 32); wait_cyc(4);
    chk("a5_data", bus.rx_data, 8'hA5);
    chk("a5_valid", bus.rx_valid, 1);
    chk("a5_ferr", bus.frame_err, 0);
    do_ack();
    chk("a5_ack_valid", bus.rx_valid, 0);
    rx = 0; wait_cyc(8); rx = 1; wait_cyc(64);
    chk("glitch_valid", bus.rx_valid, 0);
    send_frame(8'h3C, 1, 0, 32); wait_cyc(4);
    chk("3c_data", bus.rx_data, 8'h3C);
    chk("3c_valid", bus.rx_valid, 1);
    do_ack(); wait_cyc(10);
    send_frame(8'h81, 0, 0, 32); wait_cyc(4);
    chk("81_data", bus.rx_data, 8'h81);
    chk("81_ferr", bus.frame_err, 1);
    do_ack(); wait_cyc(10);
    send_frame(8'h00, 1, 0, 32); wait_cyc(4);
    chk("00_data", bus.rx_data, 8'h00);
    chk("00_ferr", bus.frame_err, 0);
    do_ack(); wait_cyc(10);
    send_frame(8'h11, 1, 0, 32);
    send_frame(8'h22, 1, 0, 32); wait_cyc(4);
    chk("b2b_data", bus.rx_data, 8'h22);
    chk("b2b_ovr", bus.overrun, 1);
    chk("b2b_valid", bus.rx_valid, 1);
    do_ack();
    chk("b2b_ack_valid", bus.rx_valid, 0);
    chk("b2b_ack_ovr", bus.overrun, 0);
    wait_cyc(10);
    fork
      send_frame(8'hFF, 1, 0, 32);
      begin
        wait_cyc(32 * 5 + 16); rst = 1; wait_cyc(2); rst = 0; wait_cyc(1);
        chk("midrst_data", bus.rx_data, 0);
        chk("midrst_valid", bus.rx_valid, 0);
        chk("midrst_ferr", bus.frame_err, 0);
        chk("midrst_ovr", bus.overrun, 0);
      end
    join
    wait_cyc(20);
    send_frame(8'h5A, 1, 0, 32); wait_cyc(4);
    chk("5a_data", bus.rx_data, 8'h5A);
    chk("5a_valid", bus.rx_valid, 1);
    chk("5a_ferr", bus.frame_err, 0);
    do_ack(); wait_cyc(10);
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1, 1, 32); wait_cyc(4);
    chk("par_ok", bus.parity_err, 0);
    do_ack(); wait_cyc(10);
    send_frame(8'h07, 1, 0, 32); wait_cyc(4);
    chk("par_bad", bus.parity_err, 1);
    do_ack(); wait_cyc(10);
`endif
    rand_ack = 1;
    for (int f = 0; f < 40; f++) begin
      logic [7:0] d;
      logic stp;
      d = 8'($urandom);
      stp = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 7) == 0) begin rx = 0; wait_cyc($urandom_range(2, 10)); rx = 1; wait_cyc(40); end
      send_frame(d, stp, ^d ^ ($urandom_range(0, 4) == 0), 31 + $urandom_range(0, 2));
      wait_cyc(stp ? $urandom_range(0, 40) : $urandom_range(8, 40));
    end
    rand_ack = 0;
    wait_cyc(50);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
